qcm_cap_switch_sequencer: RTL and testbench

//  Downstream of the frequency-measure/code-select stage in the QCM master controller.

---
 rtl/qcm_pkg.sv | 23 ++
 rtl/qcm_cycle_timer.sv | 36 +++
 rtl/qcm_cap_switch_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_qcm_cap_switch_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcm_pkg.sv
// +----------------------------------------------------------------------------+
// | qcm_pkg: shared state encoding, default code width and timer width for the |
// | QCM capacitor-bank switch sequencer.            Revision: 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

package qcm_pkg;

  localparam int CODE_W_DEFAULT = 7;
  localparam int TIMER_W        = 16;
  localparam int TIMER_MAX      = (1 << TIMER_W) - 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF    = 3'd0;
  localparam state_t ST_IDLE   = 3'd1;
  localparam state_t ST_DEAD   = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/qcm_cycle_timer.sv
// +----------------------------------------------------------------------------+
// | qcm_cycle_timer: loadable down-counter; done marks the last counted cycle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module qcm_cycle_timer
  import qcm_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Loading N makes done fire on the Nth cycle after the load edge.
  assign done = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/qcm_cap_switch_sequencer.sv
// +----------------------------------------------------------------------------+
// | qcm_cap_switch_sequencer: break-before-make application of series/parallel |
// | capacitor codes. Optional QCM_SEQ_CONFIRM_EN adds request confirmation.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module qcm_cap_switch_sequencer
  import qcm_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEFAULT,
  parameter int DEAD_CYC   = 20,
  parameter int SETTLE_CYC = 40,
  parameter int HOLD_CYC   = 4000,
  parameter int CONFIRM_N  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code_ser,
  input  logic [CODE_W-1:0] req_code_par,
  input  logic              clk_en,
  output logic [CODE_W-1:0] code_ser,
  output logic [CODE_W-1:0] code_par,
  output logic              enable_ser,
  output logic              enable_par,
  output logic              busy
);

  if (DEAD_CYC < 1 || DEAD_CYC > TIMER_MAX || SETTLE_CYC < 1 || SETTLE_CYC > TIMER_MAX ||
      HOLD_CYC < 1 || HOLD_CYC > TIMER_MAX || CONFIRM_N < 1) begin : g_bad_params
    $error("qcm_cap_switch_sequencer: timing parameters must be in 1..65535, CONFIRM_N >= 1");
  end

  localparam logic [TIMER_W-1:0] DEAD_LD   = TIMER_W'(DEAD_CYC);
  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYC);
  localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(HOLD_CYC);

  state_t              state;
  state_t              next_state;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;
  logic                timer_done;
  logic                cand_valid;
  logic                pend_valid;
  logic [CODE_W-1:0]   pend_ser;
  logic [CODE_W-1:0]   pend_par;
  logic [CODE_W-1:0]   target_ser;
  logic [CODE_W-1:0]   target_par;
  logic                src_valid;
  logic [CODE_W-1:0]   src_ser;
  logic [CODE_W-1:0]   src_par;
  logic                src_differs;
  logic                accept;
  logic                code_load;
  logic                enable_d;
  logic                busy_d;

`ifdef QCM_SEQ_CONFIRM_EN
  localparam int             CNT_W       = $clog2(CONFIRM_N + 1);
  localparam logic [CNT_W-1:0] CONFIRM_CNT = CNT_W'(CONFIRM_N);

  logic [CNT_W-1:0]  conf_cnt;
  logic [CNT_W-1:0]  conf_cnt_next;
  logic [CODE_W-1:0] last_ser;
  logic [CODE_W-1:0] last_par;

  // Saturating run length of identical strobes, including the current one.
  always_comb begin
    conf_cnt_next = CNT_W'(1);
    if (conf_cnt != '0 && req_code_ser == last_ser && req_code_par == last_par) begin
      conf_cnt_next = (conf_cnt >= CONFIRM_CNT) ? conf_cnt : conf_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_cnt <= '0;
      last_ser <= '0;
      last_par <= '0;
    end else if (!clk_en) begin
      conf_cnt <= '0;
    end else if (req_valid) begin
      conf_cnt <= conf_cnt_next;
      last_ser <= req_code_ser;
      last_par <= req_code_par;
    end
  end

  assign cand_valid = req_valid && clk_en && (conf_cnt_next >= CONFIRM_CNT);
`else
  assign cand_valid = req_valid && clk_en;
`endif

  // A fresh strobe always wins over the pending slot when HOLD expires.
  always_comb begin
    src_valid   = cand_valid || (state == ST_HOLD && pend_valid);
    src_ser     = cand_valid ? req_code_ser : pend_ser;
    src_par     = cand_valid ? req_code_par : pend_par;
    src_differs = (src_ser != code_ser) || (src_par != code_par);
  end

  qcm_cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = '0;
    accept     = 1'b0;
    if (!clk_en) begin
      next_state = ST_OFF;
      timer_load = 1'b1;
    end else begin
      case (state)
        ST_OFF:    accept = src_valid;
        ST_IDLE:   accept = src_valid && src_differs;
        ST_DEAD: begin
          if (timer_done) begin
            next_state = ST_SETTLE;
            timer_load = 1'b1;
            timer_val  = SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (timer_done) begin
            next_state = ST_HOLD;
            timer_load = 1'b1;
            timer_val  = HOLD_LD;
          end
        end
        ST_HOLD: begin
          if (timer_done) begin
            next_state = ST_IDLE;
            accept     = src_valid && src_differs;
          end
        end
        default:   next_state = ST_OFF;
      endcase
      if (accept) begin
        next_state = ST_DEAD;
        timer_load = 1'b1;
        timer_val  = DEAD_LD;
      end
    end
  end

  always_comb begin
    enable_d  = (next_state == ST_HOLD) || (next_state == ST_IDLE);
    busy_d    = (next_state == ST_DEAD) || (next_state == ST_SETTLE) || (next_state == ST_HOLD);
    code_load = (state == ST_DEAD) && (next_state == ST_SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_ser   <= '0;
      code_par   <= '0;
      enable_ser <= 1'b0;
      enable_par <= 1'b0;
      busy       <= 1'b0;
    end else begin
      enable_ser <= enable_d;
      enable_par <= enable_d;
      busy       <= busy_d;
      if (code_load) begin
        code_ser <= target_ser;
        code_par <= target_par;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_ser <= '0;
      target_par <= '0;
      pend_valid <= 1'b0;
      pend_ser   <= '0;
      pend_par   <= '0;
    end else begin
      if (accept) begin
        target_ser <= src_ser;
        target_par <= src_par;
      end
      if (!clk_en || (state == ST_HOLD && timer_done)) begin
        pend_valid <= 1'b0;
      end else if (cand_valid &&
                   (state == ST_DEAD || state == ST_SETTLE || state == ST_HOLD)) begin
        pend_valid <= 1'b1;
        pend_ser   <= req_code_ser;
        pend_par   <= req_code_par;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qcm_cap_switch_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_qcm_cap_switch_sequencer: directed bench with a cycle-level reference   |
// | model of the switching sequence.                Revision: 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_qcm_cap_switch_sequencer;

  localparam int CW = 7;
  localparam int D  = 4;
  localparam int S  = 8;
  localparam int H  = 16;
  localparam int N  = 3;
`ifdef QCM_SEQ_CONFIRM_EN
  localparam int SN = N;
`else
  localparam int SN = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [CW-1:0] req_ser;
  logic [CW-1:0] req_par;
  logic          clk_en;
  logic [CW-1:0] code_ser;
  logic [CW-1:0] code_par;
  logic          enable_ser;
  logic          enable_par;
  logic          busy;

  qcm_cap_switch_sequencer #(
    .CODE_W     (CW),
    .DEAD_CYC   (D),
    .SETTLE_CYC (S),
    .HOLD_CYC   (H),
    .CONFIRM_N  (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_code_ser (req_ser),
    .req_code_par (req_par),
    .clk_en       (clk_en),
    .code_ser     (code_ser),
    .code_par     (code_par),
    .enable_ser   (enable_ser),
    .enable_par   (enable_par),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  bit seen_20  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a sequence is a start cycle t0 plus a target; every
  // output follows from the distance to t0.
  bit            m_off, m_active, m_en, pd_v, cand, sv;
  logic [CW-1:0] m_ser, m_par, tg_ser, tg_par, pd_ser, pd_par, s_ser, s_par, c_ser, c_par;
  int            mcyc, t0, r, ccnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_off = 1'b1; m_active = 1'b0; m_en = 1'b0; pd_v = 1'b0;
      m_ser = '0; m_par = '0; mcyc = 0; ccnt = 0; c_ser = '0; c_par = '0;
    end else begin
      cand = 1'b0;
      sv   = 1'b0;
      if (!clk_en) begin
        m_off = 1'b1; m_active = 1'b0; m_en = 1'b0; pd_v = 1'b0; ccnt = 0;
      end else begin
        if (req_valid) begin
`ifdef QCM_SEQ_CONFIRM_EN
          if (ccnt > 0 && req_ser == c_ser && req_par == c_par) ccnt++;
          else ccnt = 1;
          c_ser = req_ser;
          c_par = req_par;
          cand  = (ccnt >= N);
`else
          cand = 1'b1;
`endif
        end
        if (m_active) begin
          r = mcyc - t0;
          if (r == D) begin m_ser = tg_ser; m_par = tg_par; end
          if (r == D + S) m_en = 1'b1;
          if (r == D + S + H) begin
            m_active = 1'b0;
            if (cand) begin sv = 1'b1; s_ser = req_ser; s_par = req_par; end
            else if (pd_v) begin sv = 1'b1; s_ser = pd_ser; s_par = pd_par; end
            pd_v = 1'b0;
            if (sv && (s_ser != m_ser || s_par != m_par)) begin
              m_active = 1'b1; t0 = mcyc; tg_ser = s_ser; tg_par = s_par; m_en = 1'b0;
            end
          end else if (cand) begin
            pd_v = 1'b1; pd_ser = req_ser; pd_par = req_par;
          end
        end else if (cand && (m_off || req_ser != m_ser || req_par != m_par)) begin
          m_active = 1'b1; t0 = mcyc; tg_ser = req_ser; tg_par = req_par;
          m_en = 1'b0; m_off = 1'b0;
        end
      end
      mcyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (code_ser != m_ser || code_par != m_par || enable_ser != m_en ||
          enable_par != m_en || busy != m_active) begin
        failures++;
        $display("FAIL model cycle=%0d: actual ser=%0d par=%0d en=%b%b busy=%b required ser=%0d par=%0d en=%b busy=%b",
                 cyc, code_ser, code_par, enable_ser, enable_par, busy, m_ser, m_par, m_en, m_active);
      end
      if (code_ser == 7'd20) seen_20 = 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_base();
    base = cyc + SN;
  endtask

  task automatic at_cycle(input int k);
    int n;
    n = base + k - cyc;
    if (n < 0) begin
      failures++;
      $display("FAIL schedule: actual=%0d required=%0d", cyc - base, k);
    end else if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [CW-1:0] s, input logic [CW-1:0] p);
    req_valid = 1'b1;
    req_ser   = s;
    req_par   = p;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Last (confirming) strobe is sampled at the end of relative cycle k.
  task automatic strobe_at(input int k, input logic [CW-1:0] s, input logic [CW-1:0] p);
    at_cycle(k - SN + 1);
    for (int i = 0; i < SN; i++) pulse(s, p);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_ser = '0; req_par = '0; clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_en", enable_ser, 0);
    chk("reset_code", code_ser, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full sequence from OFF
    set_base();
    strobe_at(0, 7'd5, 7'd9);
    chk("t1_busy_c1", busy, 1);
    chk("t1_en_c1", enable_ser, 0);
    at_cycle(4);  chk("t1_ser_c4", code_ser, 0);
    at_cycle(5);  chk("t1_ser_c5", code_ser, 5); chk("t1_par_c5", code_par, 9);
    at_cycle(12); chk("t1_en_c12", enable_par, 0);
    at_cycle(13); chk("t1_en_c13", enable_par, 1);
    at_cycle(28); chk("t1_busy_c28", busy, 1);
    at_cycle(29); chk("t1_busy_c29", busy, 0);

    // Same codes in IDLE are ignored
    set_base();
    strobe_at(0, 7'd5, 7'd9);
    at_cycle(3); chk("t2_busy", busy, 0); chk("t2_en", enable_ser, 1);

    // Last request wins while busy
    set_base();
    strobe_at(0, 7'd12, 7'd1);
    strobe_at(16, 7'd20, 7'd2);
    strobe_at(21, 7'd33, 7'd3);
    at_cycle(27); chk("t3_ser_first", code_ser, 12); chk("t3_par_first", code_par, 1);
    at_cycle(33); chk("t3_ser_pend", code_ser, 33); chk("t3_par_pend", code_par, 3);
    at_cycle(57); chk("t3_idle", busy, 0);
    chk("t3_never_20", seen_20, 0);

    // Strobe on the HOLD-expiry cycle overrides pending
    set_base();
    strobe_at(0, 7'd40, 7'd4);
    strobe_at(20, 7'd41, 7'd4);
    strobe_at(28, 7'd42, 7'd4);
    at_cycle(33); chk("t3b_ser", code_ser, 42);
    at_cycle(57); chk("t3b_idle", busy, 0);

    // Pending equal to applied is discarded
    set_base();
    strobe_at(0, 7'd50, 7'd5);
    strobe_at(20, 7'd50, 7'd5);
    at_cycle(31); chk("t3c_busy", busy, 0); chk("t3c_en", enable_ser, 1);

    // Watchdog drop during SETTLE
    set_base();
    strobe_at(0, 7'd1, 7'd2);
    at_cycle(7); clk_en = 1'b0;
    at_cycle(8); chk("t4_busy", busy, 0); chk("t4_en", enable_ser, 0); chk("t4_ser", code_ser, 1);
    strobe_at(10, 7'd9, 7'd9);
    at_cycle(12); chk("t4_ignored", busy, 0); clk_en = 1'b1;
    at_cycle(20); chk("t4_stays_off", enable_ser, 0);
    strobe_at(22, 7'd1, 7'd2);
    chk("t4_reseq", busy, 1);
    at_cycle(35); chk("t4_en_back", enable_ser, 1);
    at_cycle(51); chk("t4_idle", busy, 0);

    // Asynchronous reset mid-DEAD
    set_base();
    strobe_at(0, 7'd3, 7'd3);
    at_cycle(2);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_ser", code_ser, 0); chk("t5_par", code_par, 1 - 1); chk("t5_en", enable_ser, 0);
    chk("t5_busy", busy, 0);
    at_cycle(4); rst_n = 1'b1;
    at_cycle(6); chk("t5_off_en", enable_ser, 0);
    strobe_at(8, 7'd0, 7'd0);
    chk("t5_off_accepts_equal", busy, 1);
    at_cycle(37); chk("t5_done_en", enable_ser, 1); chk("t5_done_busy", busy, 0);

`ifdef QCM_SEQ_CONFIRM_EN
    set_base();
    at_cycle(0);
    pulse(7'd7, 7'd0); pulse(7'd7, 7'd0); pulse(7'd8, 7'd0); pulse(7'd8, 7'd0);
    chk("t6_not_yet", busy, 0);
    pulse(7'd8, 7'd0);
    chk("t6_started", busy, 1);
    at_cycle(8);  chk("t6_ser_before", code_ser, 0);
    at_cycle(9);  chk("t6_ser_8", code_ser, 8);
    at_cycle(33); chk("t6_idle", busy, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
